// File: rtl/serial_frame_rx_pkg.sv
// Shared types and defaults for the serial frame receiver.
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int unsigned SYNC_LEN_DEF = 4;
  localparam logic [15:0] SYNC_PAT_DEF = 16'h000B;

  // Bit-counter width for a payload of the given length.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_frame_rx_sync_detect.sv
// Sync hunter: shift register of recent bits with a saturating fill count.
module sync_detect #(
  parameter int unsigned         SYNC_LEN = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT = '0
) (
  input  logic clock,
  input  logic reset,
  input  logic serial_bit,
  input  logic bit_en,
  input  logic clear,
  output logic match_c
);

  localparam int unsigned FW = $clog2(SYNC_LEN + 1);

  logic [SYNC_LEN-1:0] shift_q, shift_s, shift_d;
  logic [FW-1:0]       fill_q, fill_s, fill_d;

  // Match is judged on the post-shift value; clear wins over the shift.
  always_comb begin
    shift_s = shift_q;
    fill_s  = fill_q;
    if (bit_en) begin
      shift_s = SYNC_LEN'({shift_q, serial_bit});
      fill_s  = (fill_q == FW'(SYNC_LEN)) ? fill_q : fill_q + FW'(1);
    end
    shift_d = clear ? '0 : shift_s;
    fill_d  = clear ? '0 : fill_s;
    match_c = bit_en && !clear && (fill_s == FW'(SYNC_LEN)) && (shift_s == SYNC_PAT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      fill_q  <= '0;
    end else begin
      shift_q <= shift_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: sync hunt, MSB-first payload, valid/ready output.
// Optional even-parity bit per frame under SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int unsigned         WIDTH    = 8,
  parameter int unsigned         SYNC_LEN = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_LEN'(SYNC_PAT_DEF)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] payload_q, payload_d, data_d, word_c;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             valid_d, busy_d, overrun_d, parity_err_d;
  logic             match_c, frame_done_c, last_bit_c, in_hunt_c;

  assign in_hunt_c = (state_q == HUNT);

  // Held cleared outside HUNT so every return starts a fresh hunt.
  sync_detect #(
    .SYNC_LEN (SYNC_LEN),
    .SYNC_PAT (SYNC_PAT)
  ) u_sync_detect (
    .clock      (clock),
    .reset      (reset),
    .serial_bit (serial_in),
    .bit_en     (bit_en),
    .clear      (!in_hunt_c),
    .match_c    (match_c)
  );

  always_comb begin
    state_d      = state_q;
    payload_d    = payload_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_out;
    valid_d      = valid;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;
    frame_done_c = 1'b0;
    word_c       = payload_q;
    last_bit_c   = (bit_cnt_q == CW'(WIDTH - 1));

    if (bit_en) begin
      unique case (state_q)
        HUNT: begin
          if (match_c) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          payload_d = {payload_q[WIDTH-2:0], serial_in};
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (last_bit_c) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d      = HUNT;
            frame_done_c = 1'b1;
            word_c       = payload_d;
`endif
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        PARITY: begin
          state_d = HUNT;
          if ((^payload_q) == serial_in) frame_done_c = 1'b1;
          else                           parity_err_d = 1'b1;
        end
`endif
        default: state_d = HUNT;
      endcase
    end

    // A finished frame loads only if the output slot is free this edge.
    if (frame_done_c) begin
      if (!valid || ready) begin
        data_d  = word_c;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid && ready) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != HUNT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      payload_q  <= '0;
      bit_cnt_q  <= '0;
      data_out   <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      payload_q  <= payload_d;
      bit_cnt_q  <= bit_cnt_d;
      data_out   <= data_d;
      valid      <= valid_d;
      busy       <= busy_d;
      overrun    <= overrun_d;
      parity_err <= parity_err_d;
    end
  end

endmodule
